// File: rtl/ifetch_queue_if.sv
// Fetch-to-decode bundle: the PC-side capture signals and the decode-side valid/ready head.
// master drives fetch data, flush and dec_ready; slave is the queue itself.
interface ifetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_instr;
    logic          fetch_stall;
    logic          flush;
    logic          dec_ready;
    logic          dec_valid;
    logic [31:0]   dec_pc;
    logic [31:0]   dec_instr;
    logic [31:0]   dec_pc8;
    logic [CW-1:0] count;

    modport master (
        output fetch_pc, fetch_instr, flush, dec_ready,
        input  fetch_stall, dec_valid, dec_pc, dec_instr, dec_pc8, count
    );

    modport slave (
        input  fetch_pc, fetch_instr, flush, dec_ready,
        output fetch_stall, dec_valid, dec_pc, dec_instr, dec_pc8, count
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: captures {pc, instr} every unstalled cycle and hands
// the oldest entry to decode over valid/ready; flush empties it on a redirect.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   mem_q [DEPTH];

    logic full;
    logic push;
    logic pop;
    logic head_valid;

    // Stall comes from registered occupancy only, so a same-cycle pop never unstalls.
    assign full       = (count_q == CW'(DEPTH));
    assign head_valid = (count_q != '0);
    assign push       = !reset && !bus.flush && !full;
    assign pop        = head_valid && bus.dec_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; occupancy alone decides what is valid.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == AW'(gi))) begin
                mem_q[gi] <= {bus.fetch_pc, bus.fetch_instr};
            end
        end
    end

    logic [63:0] head;
    assign head = mem_q[rd_ptr_q];

    assign bus.fetch_stall = full;
    assign bus.dec_valid   = head_valid;
    assign bus.dec_pc      = head_valid ? head[63:32] : RESET_PC;
    assign bus.dec_instr   = head_valid ? head[31:0]  : 32'h0000_0000;
    assign bus.dec_pc8     = bus.dec_pc + 32'd8;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a queue-of-entries model predicts every output
// each cycle, with literal spot checks pinning key points of the scenarios.
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifetch_queue_if #(.DEPTH(DEPTH)) bus ();

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] model_q[$];
    logic [31:0] pc;
    logic [31:0] redirect_pc;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected outputs follow from occupancy and the oldest queued entry only.
    task automatic compare_model();
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
        e_valid = (model_q.size() != 0);
        e_pc    = e_valid ? model_q[0][63:32] : RESET_PC;
        e_instr = e_valid ? model_q[0][31:0]  : 32'h0;
        check("dec_valid",   32'(bus.dec_valid),   32'(e_valid));
        check("dec_pc",      bus.dec_pc,           e_pc);
        check("dec_instr",   bus.dec_instr,        e_instr);
        check("dec_pc8",     bus.dec_pc8,          e_pc + 32'd8);
        check("count",       32'(bus.count),       32'(model_q.size()));
        check("fetch_stall", 32'(bus.fetch_stall), 32'(model_q.size() == DEPTH));
    endtask

    // One clock: drive at negedge, compare, then advance model and PC for the coming posedge.
    task automatic step(input logic rst, input logic fl, input logic rdy);
        logic stall_now, valid_now;
        @(negedge clk);
        reset           = rst;
        bus.flush       = fl;
        bus.dec_ready   = rdy;
        bus.fetch_pc    = pc;
        bus.fetch_instr = imem(pc);
        #1;
        compare_model();
        stall_now = (model_q.size() == DEPTH);
        valid_now = (model_q.size() != 0);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            if (valid_now && rdy) void'(model_q.pop_front());
            if (!stall_now) model_q.push_back({pc, imem(pc)});
        end
        if (fl && !rst)          pc = redirect_pc;
        else if (!rst && !stall_now) pc = pc + 32'd4;
    endtask

    initial begin
        logic [31:0] ready_pat;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.dec_ready = 1'b0;
        bus.fetch_pc = '0;
        bus.fetch_instr = '0;
        pc = 32'h0000_3000;
        redirect_pc = 32'h0000_3000;

        // 1: stream with decode always ready
        step(1'b1, 1'b0, 1'b1);
        model_q.delete();
        pc = 32'h0000_3000;
        step(1'b0, 1'b0, 1'b1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_pc",    bus.dec_pc,     32'h0000_3000);
        check("rst_pc8",   bus.dec_pc8,    32'h0000_3008);
        check("rst_stall", 32'(bus.fetch_stall), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("first_head", bus.dec_pc, 32'h0000_3000);
        step(1'b0, 1'b0, 1'b1);
        check("second_head", bus.dec_pc, 32'h0000_3004);
        check("steady_count", 32'(bus.count), 32'd1);
        step(1'b0, 1'b0, 1'b1);

        // 2: decode stalls, queue fills
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
        check("full_count", 32'(bus.count), 32'd4);
        check("full_stall", 32'(bus.fetch_stall), 32'd1);

        // 3: single pop while full, then drain with decode ready
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("after_pop_count", 32'(bus.count), 32'd3);
        check("after_pop_stall", 32'(bus.fetch_stall), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);

        // 4: refill three from 0x3004, flush while fetch_pc is 0x3010
        redirect_pc = 32'h0000_3004;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        redirect_pc = 32'h0000_4000;
        step(1'b0, 1'b1, 1'b0);
        check("preflush_count", 32'(bus.count), 32'd3);
        check("preflush_fpc",   bus.fetch_pc,   32'h0000_3010);
        step(1'b0, 1'b0, 1'b1);
        check("flush_valid", 32'(bus.dec_valid), 32'd0);
        check("flush_pc",    bus.dec_pc,         32'h0000_3000);
        check("flush_count", 32'(bus.count),     32'd0);

        // 5: irregular decode readiness across several pointer wraps
        ready_pat = 32'b1011_0010_1110_0100_1101_0001_0111_1001;
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, ready_pat[i]);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

        // 6: reset at count 2, then a head at the top of the address space
        redirect_pc = 32'h0000_5000;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("rst2_pre_count", 32'(bus.count), 32'd2);
        pc = 32'hFFFF_FFFC;
        step(1'b0, 1'b0, 1'b0);
        check("rst2_count", 32'(bus.count),       32'd0);
        check("rst2_valid", 32'(bus.dec_valid),   32'd0);
        check("rst2_stall", 32'(bus.fetch_stall), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("wrap_pc",  bus.dec_pc,  32'hFFFF_FFFC);
        check("wrap_pc8", bus.dec_pc8, 32'h0000_0004);
        step(1'b0, 1'b0, 1'b1);
        check("after_wrap_pc", bus.dec_pc, 32'h0000_0000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
